// File: rtl/ram_writer_if.sv
// BRAM port bundle between the write-verify controller and a single-port block RAM.
// The master drives address, write enable and write data; the RAM returns read data.
interface ram_writer_if;
   logic [9:0]  addr;
   logic        wea;
   logic [31:0] out_data;
   logic [31:0] in_data;

   modport master (output addr, output wea, output out_data, input in_data);
   modport slave  (input addr, input wea, input out_data, output in_data);
endinterface

// File: rtl/ram_writer.sv
// Button-triggered BRAM write-then-verify controller.
// Each press writes one replicated byte, reads it back after READ_LAT cycles and reports the result.
module ram_writer #(
   parameter int unsigned READ_LAT  = 4,
   parameter logic [9:0]  BASE_ADDR = 10'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_n,
   input  logic             sw_e,
   input  logic             sw_s,
   input  logic             sw_w,
   input  logic [7:0]       sw_data,
   ram_writer_if.master     bram,
   output logic [7:0]       led,
   output logic             err,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, WRITE, WAIT_RD, HOLD} state_e;

   localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

   state_e      state_q, state_d;
   logic [9:0]  addr_q, addr_d;
   logic        wea_q, wea_d;
   logic [31:0] out_data_q, out_data_d;
   logic [7:0]  led_q, led_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [2:0]  cnt_q, cnt_d;

   logic        any_btn;
   logic [1:0]  btn_idx;

   assign any_btn = sw_n | sw_e | sw_s | sw_w;

   always_comb begin
      if (sw_n)      btn_idx = 2'd0;
      else if (sw_e) btn_idx = 2'd1;
      else if (sw_s) btn_idx = 2'd2;
      else           btn_idx = 2'd3;
   end

   always_comb begin
      // NOTE: every next-state signal starts from a hold/default value so no path leaves it unassigned (no latches).
      state_d    = state_q;
      addr_d     = addr_q;
      wea_d      = wea_q;
      out_data_d = out_data_q;
      led_d      = led_q;
      err_d      = err_q;
      done_d     = 1'b0;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (any_btn) begin
               addr_d     = BASE_ADDR + {8'd0, btn_idx};
               out_data_d = {4{sw_data}};
               wea_d      = 1'b1;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            wea_d   = 1'b0;
            cnt_d   = 3'd0;
            state_d = WAIT_RD;
         end
         WAIT_RD: begin
            if (cnt_q == LAST_CNT) begin
               led_d   = bram.in_data[7:0];
               err_d   = (bram.in_data != out_data_q);
               done_d  = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         HOLD: begin
            // Waiting for full release is what makes a held button produce a single write.
            if (!any_btn) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= 10'd0;
         wea_q      <= 1'b0;
         out_data_q <= 32'd0;
         led_q      <= 8'd0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wea_q      <= wea_d;
         out_data_q <= out_data_d;
         led_q      <= led_d;
         err_q      <= err_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bram.addr     = addr_q;
   assign bram.wea      = wea_q;
   assign bram.out_data = out_data_q;
   assign led           = led_q;
   assign err           = err_q;
   assign done          = done_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter: READ_LAT, default 4, meaning cycles from write-enable deassertion to readback sampling; legal range 1..7.
REQ-002 Parameter: BASE_ADDR, default 10'd0, meaning address offset added to the button index.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw_n  input  1  button, level; selects address index 0.
REQ-006 sw_e  input  1  button, level; selects address index 1.
REQ-007 sw_s  input  1  button, level; selects address index 2.
REQ-008 sw_w  input  1  button, level; selects address index 3.
REQ-009 sw_data  input  8  data switches; write byte source.
REQ-010 in_data  input  32  BRAM read-data port, same address as addr.
REQ-011 addr  output  10  BRAM address, registered.
REQ-012 wea  output  1  BRAM write enable, registered.
REQ-013 out_data  output  32  BRAM write data, registered.
REQ-014 led  output  8  readback byte display, registered.
REQ-015 err  output  1  readback mismatch flag, registered.
REQ-016 done  output  1  one-cycle pulse, write-verify complete.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, WAIT_RD, HOLD; no other reachable states.
REQ-019 IDLE, any button high: priority n > e > s > w; addr <= BASE_ADDR + index (10-bit wrap); out_data <= {4{sw_data}}; wea <= 1; go WRITE.
REQ-020 IDLE, no button: all outputs hold; done <= 0.
REQ-021 WRITE: exactly one cycle; wea <= 0; counter <= 0; go WAIT_RD.
REQ-022 WAIT_RD, counter != READ_LAT-1: counter increments; addr and out_data hold.
REQ-023 WAIT_RD, counter == READ_LAT-1: led <= in_data[7:0]; err <= (in_data != out_data), full 32-bit compare; done <= 1; go HOLD.
REQ-024 HOLD: done <= 0; stay until all four buttons low, then go IDLE.
REQ-025 Latency: button sampled at edge E0; wea high for cycle E0..E1 only; led/err/done update at edge E(1+READ_LAT).
REQ-026 Exactly one write per press; a held button causes no further writes.
REQ-027 Buttons and sw_data changes outside IDLE SHALL be ignored; captured values are not altered.
REQ-028 err SHALL hold its value until the next completed verify or reset.
REQ-029 wea SHALL never be high for more than one consecutive cycle.
REQ-030 Counter width 3 bits; no wrap occurs for any legal READ_LAT.

Reset
REQ-031 rst high at an edge: state <= IDLE; addr <= 0; wea <= 0; out_data <= 0; led <= 0; err <= 0; done <= 0; counter <= 0; busy low the following cycle.
REQ-032 rst SHALL take priority over all FSM transitions, including mid-WRITE: wea drops at that same edge and no verify result is reported.
REQ-033 After reset release, a button already held SHALL start a new write from IDLE.

Verification
REQ-034 sw_data=8'hA5, pulse sw_e, BRAM model 1-cycle read -> one wea pulse, addr=1, out_data=32'hA5A5A5A5, led=8'hA5, err=0, done one cycle at E5.
REQ-035 sw_n and sw_w high together, sw_data=8'h3C -> addr=0 only, a single write.
REQ-036 sw_s held for 50 cycles, sw_data=8'h11 then 8'h22 mid-hold -> exactly one write of 32'h11111111; IDLE only after release.
REQ-037 BRAM model forced to return 32'h000000A5 after writing 8'hA5 -> led=8'hA5, err=1; err stays 1 until next clean verify clears it.
REQ-038 rst asserted the cycle wea is high -> wea=0 next cycle, all outputs 0, no done pulse; next press operates normally.
REQ-039 READ_LAT=1, BASE_ADDR=10'h3FE, press sw_s -> addr=10'h000 (wrap), done at E2.
